// File: rtl/affine_transform_pipe_pkg.sv
// Shared types for the affine transform pipeline: share-derived state width,
// GF(2) matrix type, the coefficient pair and the bank index.
package affine_transform_pipe_pkg;

    // Masking/share dimension; state width is derived from it.
    localparam int SHARE_D = 2;
    localparam int STATE_W = 4 * SHARE_D;

    // Bank index width (two banks: active and shadow).
    localparam int BANK_W = 1;

    typedef logic [STATE_W-1:0] state_t;

    // Row i of the matrix produces output bit i: y[i] = XOR_j (m[i][j] & x[j]).
    typedef logic [STATE_W-1:0][STATE_W-1:0] rr_matrix_t;

    typedef logic [BANK_W-1:0] bank_idx_t;

    // One coefficient set: linear part T and translation t.
    typedef struct packed {
        rr_matrix_t T;
        state_t     t;
    } affine_coef_t;

    // Vector addition over GF(2): bitwise XOR, no carries.
    function automatic state_t gf2_add(input state_t a, input state_t b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/affine_transform_pipe_coef_bank.sv
// Double-buffered coefficient store. Software writes the shadow bank while the
// datapath reads the active bank; a swap exchanges the roles atomically.
module affine_coef_bank
    import affine_transform_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  affine_coef_t cfg_coef,
    input  logic         cfg_we,
    input  logic         cfg_swap,
    output affine_coef_t active_coef,
    output bank_idx_t    active_bank,
    output logic         coef_ready
);

    affine_coef_t banks [2];
    bank_idx_t    active_q;
    logic         shadow_loaded;
    logic         coef_ready_q;
    logic         swap_ok;

    // A swap is honoured only when the shadow holds fresh values, including
    // values being written in this very cycle (write-then-swap).
    assign swap_ok = cfg_swap & (shadow_loaded | cfg_we);

    // Coefficient storage: writes always land in the bank that is not active.
    always_ff @(posedge clk) begin
        // NOTE: this small two-entry store is cleared on reset because the
        // coefficients must read as zero after reset; large RAMs would not be.
        if (rst) begin
            banks[0] <= '0;
            banks[1] <= '0;
        end else if (cfg_we) begin
            banks[~active_q] <= cfg_coef;
        end
    end

    // Active pointer and status flags.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            active_q      <= '0;
            shadow_loaded <= 1'b0;
            coef_ready_q  <= 1'b0;
        end else if (swap_ok) begin
            // Old active coefficients stay in the shadow but count as stale.
            active_q      <= ~active_q;
            shadow_loaded <= 1'b0;
            coef_ready_q  <= 1'b1;
        end else if (cfg_we) begin
            shadow_loaded <= 1'b1;
        end
    end

    assign active_coef = banks[active_q];
    assign active_bank = active_q;
    assign coef_ready  = coef_ready_q;

endmodule

// File: rtl/matrix_mul.sv
// GF(2) matrix-vector product. Rows are evaluated share-group by share-group
// so the row ordering follows the masking dimension d.
module matrix_mul
    import affine_transform_pipe_pkg::*;
#(
    parameter int d = 2
) (
    input  rr_matrix_t mat,
    input  state_t     vec,
    output state_t     prod
);

    localparam int GROUPS = STATE_W / d;

    // Each output bit is the parity of its matrix row masked by the input vector.
    always_comb begin
        // NOTE: give every combinational output a default first so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        prod = '0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int s = 0; s < d; s++) begin
                prod[g*d+s] = ^(mat[g*d+s] & vec);
            end
        end
    end

endmodule

// File: rtl/affine_transform_pipe.sv
// Pipelined, handshaked GF(2) affine transform out = T*in ^ t over CH channels
// sharing one double-buffered coefficient set. Stage 1 registers the linear
// product and captures t plus the bank tag; stage 2 (optional) registers the XOR.
module affine_transform_pipe
    import affine_transform_pipe_pkg::*;
#(
    parameter int d       = 2,
    parameter int CH      = 1,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  state_t [CH-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output state_t [CH-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output bank_idx_t         out_bank,
    input  rr_matrix_t        cfg_T,
    input  state_t            cfg_t,
    input  logic              cfg_we,
    input  logic              cfg_swap,
    output bank_idx_t         active_bank,
    output logic              coef_ready
);

    affine_coef_t    cfg_coef;
    affine_coef_t    act_coef;
    state_t [CH-1:0] lin;

    logic            s1_valid;
    state_t [CH-1:0] s1_lin;
    state_t          s1_t;
    bank_idx_t       s1_bank;
    state_t [CH-1:0] s1_sum;
    logic            s1_adv;
    logic            s1_load;
    logic            accept;

    assign cfg_coef = '{T: cfg_T, t: cfg_t};

    affine_coef_bank u_coef_bank (
        .clk         (clk),
        .rst         (rst),
        .cfg_coef    (cfg_coef),
        .cfg_we      (cfg_we),
        .cfg_swap    (cfg_swap),
        .active_coef (act_coef),
        .active_bank (active_bank),
        .coef_ready  (coef_ready)
    );

    // One linear-part multiplier per channel, all reading the active matrix.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        matrix_mul #(.d(d)) u_mul (
            .mat  (act_coef.T),
            .vec  (in_data[c]),
            .prod (lin[c])
        );
    end

    // Stage 1 may load when empty or when its beat moves on this cycle; no
    // beat enters until a coefficient set has been made active.
    assign s1_load  = ~s1_valid | s1_adv;
    assign in_ready = coef_ready & s1_load;
    assign accept   = in_valid & in_ready;

    // Stage 1: linear product per channel, with the translation and bank tag
    // captured so a later swap cannot affect this beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lin   <= '0;
            s1_t     <= '0;
            s1_bank  <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_lin  <= lin;
                s1_t    <= act_coef.t;
                s1_bank <= active_bank;
            end
        end
    end

    // Translation add on the stage-1 beat.
    always_comb begin
        s1_sum = '0;
        for (int c = 0; c < CH; c++) begin
            s1_sum[c] = gf2_add(s1_lin[c], s1_t);
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic            s2_valid;
        state_t [CH-1:0] s2_data;
        bank_idx_t       s2_bank;

        // Stage 2 loads when empty or when downstream takes its beat.
        assign s1_adv = ~s2_valid | out_ready;

        // Stage 2: registered result; holds steady while stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
                s2_bank  <= '0;
            end else if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_sum;
                    s2_bank <= s1_bank;
                end
            end
        end

        assign out_valid = s2_valid;
        assign out_data  = s2_data;
        assign out_bank  = s2_bank;
    end else begin : g_comb_out
        // Stage 1 drives the output directly through the XOR.
        assign s1_adv    = out_ready;
        assign out_valid = s1_valid;
        assign out_data  = s1_sum;
        assign out_bank  = s1_bank;
    end

endmodule

// File: tb/tb_affine_transform_pipe.sv
// Self-checking bench for affine_transform_pipe (CH=2, REG_OUT=1): directed
// scenarios plus randomized traffic against a value-level reference model.
module tb_affine_transform_pipe;
    import affine_transform_pipe_pkg::*;

    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    state_t [CH-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    state_t [CH-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    bank_idx_t       out_bank;
    rr_matrix_t      cfg_T;
    state_t          cfg_t;
    logic            cfg_we;
    logic            cfg_swap;
    bank_idx_t       active_bank;
    logic            coef_ready;

    affine_transform_pipe #(.d(2), .CH(CH), .REG_OUT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bank    (out_bank),
        .cfg_T       (cfg_T),
        .cfg_t       (cfg_t),
        .cfg_we      (cfg_we),
        .cfg_swap    (cfg_swap),
        .active_bank (active_bank),
        .coef_ready  (coef_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        state_t [CH-1:0] data;
        bit              bank;
        int              acc;
        bit              exact;
    } sb_entry_t;

    sb_entry_t sb[$];
    state_t    obs_data[$];
    bit        obs_bank[$];
    bit        exact_lat = 1'b0;
    int        n_acc = 0;

    // Reference model: active and shadow coefficient values, exchanged on swap.
    rr_matrix_t m_act_T, m_sh_T;
    state_t     m_act_t, m_sh_t;
    bit         m_bank, m_loaded, m_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // y = T*x + t over GF(2): bit i is the parity of row i masked by x.
    function automatic state_t model_apply(input rr_matrix_t mat, input state_t vec, input state_t x);
        state_t y = '0;
        for (int i = 0; i < STATE_W; i++) y[i] = (($countones(mat[i] & x) % 2) == 1);
        return y ^ vec;
    endfunction

    function automatic rr_matrix_t identity();
        rr_matrix_t m = '0;
        for (int i = 0; i < STATE_W; i++) m[i][i] = 1'b1;
        return m;
    endfunction

    // One clock cycle: inputs were set at the preceding negedge. Predict what
    // the coming edge does, then check the coefficient status after it.
    task automatic tick();
        sb_entry_t e;
        #1;
        if (rst) begin
            sb.delete();
            m_act_T = '0; m_act_t = '0; m_sh_T = '0; m_sh_t = '0;
            m_bank = 1'b0; m_loaded = 1'b0; m_ready = 1'b0;
        end else begin
            if (!m_ready) check("in_ready gated", 64'(in_ready), 0);
            if (in_valid && in_ready) begin
                for (int c = 0; c < CH; c++) e.data[c] = model_apply(m_act_T, m_act_t, in_data[c]);
                e.bank  = m_bank;
                e.acc   = cyc;
                e.exact = exact_lat;
                sb.push_back(e);
                n_acc++;
            end
            if (cfg_we) begin
                m_sh_T = cfg_T; m_sh_t = cfg_t; m_loaded = 1'b1;
            end
            if (cfg_swap && m_loaded) begin
                rr_matrix_t tmp_T = m_act_T;
                state_t     tmp_t = m_act_t;
                m_act_T = m_sh_T; m_act_t = m_sh_t;
                m_sh_T  = tmp_T;  m_sh_t  = tmp_t;
                m_bank   = ~m_bank;
                m_loaded = 1'b0;
                m_ready  = 1'b1;
            end
        end
        @(negedge clk);
        check("active_bank", 64'(active_bank), 64'(m_bank));
        check("coef_ready", 64'(coef_ready), 64'(m_ready));
    endtask

    task automatic load_coef(input rr_matrix_t mat, input state_t vec);
        cfg_T = mat; cfg_t = vec; cfg_we = 1'b1; cfg_swap = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_swap = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("scoreboard drained", 64'(sb.size()), 0);
    endtask

    // Monitor: compares each transferred output beat against the scoreboard
    // and verifies that a stalled output holds steady.
    bit              prev_stall = 1'b0;
    state_t [CH-1:0] prev_data;
    bit              prev_bank;

    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall valid held", 64'(out_valid), 1);
                    check("stall data held", 64'(out_data), 64'(prev_data));
                    check("stall bank held", 64'(out_bank), 64'(prev_bank));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected beat: got %0h, want no beat", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_bank", 64'(out_bank), 64'(e.bank));
                        check("latency min", 64'(cyc - e.acc >= 2), 1);
                        if (e.exact) check("latency exact", 64'(cyc - e.acc), 2);
                        obs_data.push_back(out_data[0]);
                        obs_bank.push_back(out_bank);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_bank  = out_bank;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int acc_before;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_T = '0; cfg_t = '0; cfg_we = 1'b0; cfg_swap = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset state.
        rst = 1'b0;
        check("reset out_valid", 64'(out_valid), 0);
        check("reset out_data", 64'(out_data), 0);
        check("reset out_bank", 64'(out_bank), 0);

        // 1. Gating: nothing accepted before the first honoured swap.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {8'($urandom), 8'($urandom)};
            check("gate in_ready", 64'(in_ready), 0);
            check("gate out_valid", 64'(out_valid), 0);
            tick();
        end
        in_valid = 1'b0;
        cfg_T = identity(); cfg_t = 8'h5A; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("write leaves coef_ready", 64'(coef_ready), 0);
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        check("swap coef_ready", 64'(coef_ready), 1);
        check("swap active_bank", 64'(active_bank), 1);

        // 2. Basic transform with fixed latency.
        exact_lat = 1'b1;
        in_data[0] = 8'h33; in_data[1] = 8'hFF; in_valid = 1'b1;
        check("basic in_ready", 64'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("basic n+1 out_valid", 64'(out_valid), 0);
        tick();
        check("basic n+2 out_valid", 64'(out_valid), 1);
        check("basic ch0", 64'(out_data[0]), 64'h69);
        check("basic ch1", 64'(out_data[1]), 64'hA5);
        check("basic bank", 64'(out_bank), 1);
        tick();

        // 3. Mid-stream write-then-swap while beat 2 is accepted.
        obs_data.delete(); obs_bank.delete();
        for (int b = 0; b < 4; b++) begin
            in_data = {8'h01, 8'h01}; in_valid = 1'b1;
            if (b == 1) begin
                cfg_T = '0; cfg_t = 8'hC3; cfg_we = 1'b1; cfg_swap = 1'b1;
            end
            check("stream in_ready", 64'(in_ready), 1);
            tick();
            cfg_we = 1'b0; cfg_swap = 1'b0;
        end
        drain();
        exact_lat = 1'b0;
        check("swap beats seen", 64'(obs_data.size()), 4);
        if (obs_data.size() == 4) begin
            check("beat1 data", 64'(obs_data[0]), 64'h5B);
            check("beat2 data", 64'(obs_data[1]), 64'h5B);
            check("beat3 data", 64'(obs_data[2]), 64'hC3);
            check("beat4 data", 64'(obs_data[3]), 64'hC3);
            check("beat1 bank", 64'(obs_bank[0]), 1);
            check("beat2 bank", 64'(obs_bank[1]), 1);
            check("beat3 bank", 64'(obs_bank[2]), 0);
            check("beat4 bank", 64'(obs_bank[3]), 0);
        end

        // 5. Swap pulses with nothing loaded are ignored.
        for (int i = 0; i < 2; i++) begin
            cfg_swap = 1'b1;
            tick();
            cfg_swap = 1'b0;
            check("ignored swap bank", 64'(active_bank), 0);
            tick();
        end

        // 4. Back-pressure during a continuous stream.
        load_coef({$urandom, $urandom}, 8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = {8'($urandom), 8'($urandom)};
            out_ready = !(i >= 6 && i < 11);
            if (i == 6) acc_before = n_acc;
            tick();
            if (i == 10) begin
                check("stall accepts bounded", 64'(n_acc - acc_before <= 2), 1);
                check("stall in_ready low", 64'(in_ready), 0);
            end
        end
        drain();

        // Randomized traffic with coefficient updates and swaps.
        load_coef({$urandom, $urandom}, 8'($urandom));
        for (int i = 0; i < 1500; i++) begin
            in_data   = {8'($urandom), 8'($urandom)};
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            cfg_T     = {$urandom, $urandom};
            cfg_t     = 8'($urandom);
            cfg_we    = ($urandom_range(15, 0) == 0);
            cfg_swap  = ($urandom_range(11, 0) == 0);
            tick();
        end
        cfg_we = 1'b0; cfg_swap = 1'b0;
        drain();

        // 6. Reset with two beats in flight.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = {8'($urandom), 8'($urandom)};
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-reset out_valid", 64'(out_valid), 0);
        check("post-reset coef_ready", 64'(coef_ready), 0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("no stale beat", 64'(out_valid), 0);
            tick();
        end
        in_valid = 1'b0;
        check("post-reset scoreboard", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
